// File: rtl/layer_sequencer.sv
// layer_sequencer: address/issue sequencer and MAC control for one time-multiplexed dense layer
// Ports: clk, rst_n (async active-low); start/stall control in;
//        w_addr/w_ren/x_addr to weight memory and input buffer;
//        mac_valid/mac_first/mac_last/neuron_idx to the MAC; busy/done status out.
module layer_sequencer #(
   parameter int N_INPUT = 16,
   parameter int N_NEURON = 8,
   parameter int RD_LAT = 1,
   localparam int T = N_INPUT * N_NEURON,
   localparam int WA = $clog2(T),
   localparam int XA = $clog2(N_INPUT),
   localparam int NA = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stall,
   output logic [WA-1:0] w_addr,
   output logic          w_ren,
   output logic [XA-1:0] x_addr,
   output logic          mac_valid,
   output logic          mac_first,
   output logic          mac_last,
   output logic [NA-1:0] neuron_idx,
   output logic          busy,
   output logic          done
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t st;
   logic [WA-1:0] a, ca;
   logic [XA-1:0] i, ci;
   logic [NA-1:0] n, cn;
   logic [RD_LAT:0] v, f, l;
   logic [NA-1:0] nn [0:RD_LAT];
   logic iss, ci_last, empty;
   // Stage 0 of the tag pipeline is the issue itself (w_ren); stage RD_LAT lines up with read data.
   assign w_ren = v[0];
   assign mac_valid = v[RD_LAT];
   assign mac_first = f[RD_LAT];
   assign mac_last = l[RD_LAT];
   assign neuron_idx = nn[RD_LAT];
   // The start edge already issues address 0, so in IDLE the counters are taken as zero.
   always_comb begin
      iss = !stall && (st == RUN || (st == IDLE && start));
      ca = (st == IDLE) ? '0 : a;
      ci = (st == IDLE) ? '0 : i;
      cn = (st == IDLE) ? '0 : n;
      ci_last = ci == XA'(N_INPUT - 1);
      empty = ~|v[RD_LAT-1:0];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= IDLE;
         a <= '0;
         i <= '0;
         n <= '0;
         v <= '0;
         f <= '0;
         l <= '0;
         for (int k = 0; k <= RD_LAT; k++) nn[k] <= '0;
         w_addr <= '0;
         x_addr <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         v <= {v[RD_LAT-1:0], iss};
         f <= {f[RD_LAT-1:0], iss && ci == '0};
         l <= {l[RD_LAT-1:0], iss && ci_last};
         nn[0] <= iss ? cn : '0;
         for (int k = 1; k <= RD_LAT; k++) nn[k] <= nn[k-1];
         done <= 1'b0;
         if (st == IDLE) begin
            a <= '0;
            i <= '0;
            n <= '0;
         end
         if (st == IDLE && start) begin
            st <= RUN;
            busy <= 1'b1;
         end
         if (iss) begin
            w_addr <= ca;
            x_addr <= ci;
            a <= ca + 1'b1;
            i <= ci_last ? '0 : ci + 1'b1;
            n <= ci_last ? cn + 1'b1 : cn;
            if (ca == WA'(T - 1)) st <= DRAIN;
         end
         // Leave once only the final beat remains, so done lands the cycle after it.
         if (st == DRAIN && empty) begin
            st <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end
endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Control sequencer for one time-multiplexed dense layer. Walks N_NEURON × N_INPUT weight addresses in the weight memory together with the matching input-buffer address, one pair per cycle. Delays the read strobe by the memory read latency to produce MAC control (valid/first/last plus neuron index), then signals layer completion. It sits between the layer-level start/stall control and the weight memory, input buffer and single MAC/accumulator.

## Interface
- N_INPUT, 16: inputs per neuron; ≥ 2.
- N_NEURON, 8: neurons in the layer; ≥ 1.
- RD_LAT, 1: read latency in cycles of weight memory and input buffer, from ren/address to data; ≥ 1.
- WA = $clog2(N_INPUT*N_NEURON), XA = $clog2(N_INPUT), NA = max(1, $clog2(N_NEURON)): local widths.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a layer pass; sampled only in IDLE.
- stall  in  1  pause request; suppresses new issues while high.
- w_addr  out  WA  weight memory read address.
- w_ren  out  1  weight memory read enable; also the input-buffer read enable.
- x_addr  out  XA  input buffer read address.
- mac_valid  out  1  weight/input data valid at the MAC this cycle.
- mac_first  out  1  first product of a neuron; MAC clears and loads.
- mac_last  out  1  last product of a neuron; accumulator result is final after this beat.
- neuron_idx  out  NA  neuron the current mac_valid beat belongs to.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse when the pass is complete.

## Operation
- All outputs are registered. Reset value is 0 for every output, every counter and every pipeline stage. FSM resets to IDLE.
- FSM states are IDLE, RUN and DRAIN.
- IDLE: if start=1 at an edge, go to RUN. Zero the input counter i, neuron counter n and linear address a. Start is ignored in RUN and DRAIN and does not queue.
- RUN, one issue per edge with stall=0:
  - w_ren=1, w_addr=a, x_addr=i.
  - Then a←a+1 and i←i+1.
  - When i=N_INPUT-1, i wraps to 0 and n←n+1.
  - The issue with a=N_INPUT*N_NEURON-1 is the last one; go to DRAIN after it.
- RUN with stall=1 at an edge: no issue in the following cycle (w_ren=0). Counters and addresses hold their values.
- The address is generated by incrementing a; no multiplier. w_addr never exceeds N_INPUT*N_NEURON-1.
- Every issue carries a tag {first=(i==0), last=(i==N_INPUT-1), n} into an RD_LAT-deep shift pipeline alongside w_ren. The pipeline output drives mac_valid, mac_first, mac_last and neuron_idx. mac_first, mac_last and neuron_idx are 0 whenever mac_valid=0.
- Stall is a pause request, not backpressure: up to RD_LAT beats already issued still emerge on mac_valid.
- DRAIN: wait until the pipeline is empty (the final mac_valid has left). In the next cycle, set done=1 and busy=0 and return to IDLE.
- busy=1 from the cycle after start is accepted through the cycle of the final mac_valid.
- The done cycle is an IDLE cycle: start sampled at the edge ending it is accepted.
- rst_n low at any time, including mid-RUN or mid-DRAIN: all outputs and pipeline stages go to 0 immediately and the FSM returns to IDLE. No done is issued for the aborted pass.

## Timing
- start high at edge E0 (cycle 0): first w_ren in cycle 1 with w_addr=0.
- Issue of address k, with no stall, happens in cycle 1+k.
- Matching mac_valid appears in cycle 1+k+RD_LAT.
- With no stall, define T = N_INPUT*N_NEURON:
  - w_ren is high in cycles 1..T.
  - mac_valid is high in cycles 1+RD_LAT..T+RD_LAT.
  - done is high in cycle T+RD_LAT+1.
- Each stalled edge delays all later issues, mac beats and done by exactly one cycle.
- Minimum start-to-start interval is T+RD_LAT+1 cycles.

## Test plan
- Nominal pass, N_INPUT=4, N_NEURON=2, RD_LAT=1, start in cycle 0:
  - w_ren in cycles 1–8, w_addr 0..7, x_addr 0,1,2,3,0,1,2,3.
  - mac_valid in cycles 2–9; mac_first in cycles 2 and 6; mac_last in cycles 5 and 9.
  - neuron_idx=0 in cycles 2–5 and 1 in cycles 6–9.
  - done=1 only in cycle 10; busy=1 in cycles 1–9.
- Stall, same configuration, stall high in cycles 2–3:
  - Addr 0 issues in cycle 1 and addr 1 in cycle 2.
  - w_ren=0 in cycles 3–4; addr 2 issues in cycle 5.
  - Sequence otherwise intact; done in cycle 12.
- RD_LAT=3, N_INPUT=2, N_NEURON=1, start in cycle 0:
  - Issues in cycles 1–2; mac_valid in cycles 4–5.
  - mac_first in cycle 4, mac_last in cycle 5; done in cycle 6.
- Start while busy: pulse start again in cycle 4 of the nominal pass. The pass is unchanged, done still in cycle 10, and no second pass runs.
- Back-to-back: start high in cycle 10, the done cycle. The second pass issues w_addr=0 in cycle 11 and done appears in cycle 20.
- Reset mid-run: drive rst_n low in cycle 5 of the nominal pass. All outputs go to 0 immediately; after release, no mac_valid or done appears until a new start. A new pass then runs exactly as in the nominal scenario.
